// File: rtl/spi_pkg.sv
// Shared definitions for the SPI configuration-register block.
//   state_t   : frame-decoder FSM states
//   RW_WRITE / RW_READ : value of the leading R/W bit of a frame
//   frame_len : total sclk rising edges in one frame (R/W + address + data)
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings one asynchronous pin into the clk domain and flags its edges.
//   clk, rst : system clock, asynchronous active-high reset
//   pin      : asynchronous input
//   rise     : one-cycle pulse after a synchronised 0->1 transition
//   fall     : one-cycle pulse after a synchronised 1->0 transition
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: clocked state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbour; = here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_regfile.sv
// SPI mode-0 peripheral fronting a bank of configuration registers.
// Frame (MSB first, sampled on sclk rising edges): R/W bit (1 = write),
// ADDR_W address bits, DATA_W data bits. Writes commit when ncs rises after
// a complete frame; reads return the register MSB first on cipo.
//   clk, rst  : system clock, asynchronous active-high reset
//   sclk, copi, ncs : SPI pins, asynchronous to clk
//   cipo, cipo_oe   : read data and its output enable
//   regs      : flattened registers, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe : one-cycle pulse when a write commits
//   wr_addr   : address of the last committed write
//   err       : sticky out-of-range flag, cleared by a valid write
module spi_regfile
  import spi_pkg::*;
#(
  parameter int                NUM_REGS    = 5,
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 7,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  // bit_cnt holds the number of bits already taken in the frame, so these
  // are the counts seen *while* the named bit is being sampled.
  localparam logic [CNT_W-1:0] LAST_ADDR_CNT   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] LAST_DATA_CNT   = CNT_W'(FRAME_LEN - 1);
  // Shifting starts only once the controller has sampled the data MSB.
  localparam logic [CNT_W-1:0] FIRST_SHIFT_CNT = CNT_W'(ADDR_W + 2);

  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic copi_s;

  state_t state, next_state;
  logic [CNT_W-1:0]  bit_cnt;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              bit_ok;
  logic [ADDR_W-1:0] addr_next;
  logic              addr_next_ok;
  logic              addr_ok;
  logic [DATA_W-1:0] rd_data;
  logic              commit;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (ncs),
    .rise (ncs_rise),
    .fall (ncs_fall)
  );

  // copi needs no edge detect; its chain matches the sclk chain depth so the
  // data bit lines up with sclk_rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) copi_sync_q <= '0;
    else     copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
  end
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  // A deselect in the same cycle as a clock edge drops that bit.
  assign bit_ok = sclk_rise & ~ncs_rise;

  // Address decode: both the address being completed and the held one.
  always_comb begin
    addr_next    = ADDR_W'({addr_q, copi_s});
    rd_data      = '0;
    addr_next_ok = 1'b0;
    addr_ok      = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_next == ADDR_W'(i)) begin
        rd_data      = regs_q[i];
        addr_next_ok = 1'b1;
      end
      if (addr_q == ADDR_W'(i)) addr_ok = 1'b1;
    end
  end

  assign commit = ncs_rise && (state == DONE) && (rw_q == RW_WRITE) && addr_ok;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: next_state gets a default before any branch; a path that leaves
  // it unassigned would infer a latch.
  always_comb begin
    next_state = state;
    if (ncs_rise) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (ncs_fall) next_state = CMD;
        CMD:  if (bit_ok) next_state = ADDR;
        ADDR: if (bit_ok && bit_cnt == LAST_ADDR_CNT) next_state = DATA;
        DATA: if (bit_ok && bit_cnt == LAST_DATA_CNT) next_state = DONE;
        DONE: next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cipo_oe = ((state == DATA) || (state == DONE)) && (rw_q == RW_READ);
    cipo    = cipo_oe & shift_q[DATA_W-1];
    regs    = '0;
    for (int i = 0; i < NUM_REGS; i++) regs[i*DATA_W +: DATA_W] = regs_q[i];
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      rw_q      <= RW_READ;
      addr_q    <= '0;
      data_q    <= '0;
      shift_q   <= '0;
      err       <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      // NOTE: the register bank is a handful of flops whose reset value is
      // architecturally visible, so it is reset like any other state.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      wr_strobe <= commit;

      if (ncs_fall) begin
        bit_cnt <= '0;
      end else if (bit_ok && (state inside {CMD, ADDR, DATA})) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (bit_ok) begin
        case (state)
          CMD:  rw_q <= copi_s;
          ADDR: begin
            addr_q <= addr_next;
            if (bit_cnt == LAST_ADDR_CNT) begin
              if (rw_q == RW_READ) shift_q <= rd_data;  // zero when out of range
              if (!addr_next_ok)   err     <= 1'b1;
            end
          end
          DATA:    data_q <= DATA_W'({data_q, copi_s});
          default: ;
        endcase
      end

      // The falling edge right after the load must keep the MSB on cipo.
      if (sclk_fall && state == DATA && rw_q == RW_READ && bit_cnt >= FIRST_SHIFT_CNT)
        shift_q <= shift_q << 1;

      if (commit) begin
        wr_addr <= addr_q;
        err     <= 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
          if (addr_q == ADDR_W'(i)) regs_q[i] <= data_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_regfile.sv
// Self-checking bench for spi_regfile: directed scenarios followed by random
// frames, compared against a register-array reference model through
// write/read scoreboards drained by independent monitors.
module tb_spi_regfile;

  localparam int                NUM_REGS    = 5;
  localparam int                DATA_W      = 8;
  localparam int                ADDR_W      = 7;
  localparam int                SYNC_STAGES = 2;
  localparam logic [DATA_W-1:0] RESET_VAL   = 8'h00;
  localparam int                FRAME_LEN   = 1 + ADDR_W + DATA_W;
  localparam int                HALF        = 50;  // sclk half period = 5 clk

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       sclk = 1'b0;
  logic                       copi = 1'b0;
  logic                       ncs = 1'b1;
  logic                       cipo;
  logic                       cipo_oe;
  logic [NUM_REGS*DATA_W-1:0] regs;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       err;

  spi_regfile #(
    .NUM_REGS    (NUM_REGS),
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (RESET_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .copi      (copi),
    .ncs       (ncs),
    .cipo      (cipo),
    .cipo_oe   (cipo_oe),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain array of register values plus the sticky flag.
  logic [DATA_W-1:0] model_regs [NUM_REGS];
  logic              model_err;

  typedef struct {
    logic [ADDR_W-1:0]          addr;
    logic [NUM_REGS*DATA_W-1:0] snap;
  } wr_exp_t;

  wr_exp_t           wr_q [$];
  logic [DATA_W-1:0] rd_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = RESET_VAL;
    model_err = 1'b0;
  endtask

  // Drive one frame of nbits sclk pulses. hold_cs leaves ncs low afterwards.
  task automatic spi_frame(input logic rw, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input int nbits, input bit hold_cs);
    logic [FRAME_LEN-1:0] word;
    bit                   in_range;
    word     = {rw, a, d};
    in_range = int'(a) < NUM_REGS;

    if (nbits >= 1 + ADDR_W && !in_range) model_err = 1'b1;
    if (nbits >= FRAME_LEN) begin
      if (rw && in_range && !hold_cs) begin
        model_regs[int'(a)] = d;
        model_err = 1'b0;
        wr_q.push_back('{addr: a, snap: model_flat()});
      end else if (!rw) begin
        rd_q.push_back(in_range ? model_regs[int'(a)] : '0);
      end
    end

    ncs = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < FRAME_LEN) ? word[FRAME_LEN-1-i] : 1'($urandom);
      #(HALF/2);
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
      #(HALF/2);
    end
    if (hold_cs) return;
    #(HALF);
    ncs = 1'b1;
    // Committed data must be visible within SYNC_STAGES+2 clk of ncs rising.
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1;
    check("regs_after_frame", regs, model_flat());
    check("err_after_frame", err, model_err);
    check("wr_pending", wr_q.size(), 0);
    check("rd_pending", rd_q.size(), 0);
    #(HALF);
  endtask

  // Write monitor: every strobe must match the oldest expected commit.
  always @(negedge clk) begin
    wr_exp_t e;
    if (!rst && wr_strobe) begin
      if (wr_q.size() == 0) begin
        check("wr_strobe_unexpected", wr_strobe, 1'b0);
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("regs_at_strobe", regs, e.snap);
      end
    end
  end

  // Read monitor: acts as the controller sampling cipo on sclk rising edges.
  int                mon_idx = 0;
  logic              mon_rd  = 1'b0;
  logic [DATA_W-1:0] mon_bits = '0;

  always @(negedge ncs) mon_idx = 0;

  always @(posedge sclk) begin
    if (!ncs) begin
      if (mon_idx == 0) mon_rd = ~copi;
      if (mon_idx < 1 + ADDR_W) begin
        check("cipo_oe_header", cipo_oe, 1'b0);
        check("cipo_idle", cipo, 1'b0);
      end else begin
        check("cipo_oe_data", cipo_oe, mon_rd);
        if (mon_idx < FRAME_LEN) begin
          mon_bits = {mon_bits[DATA_W-2:0], cipo};
          if (mon_idx == FRAME_LEN - 1 && mon_rd) begin
            if (rd_q.size() == 0) check("rd_frame_expected", rd_q.size(), 1);
            else                  check("rd_data", mon_bits, rd_q.pop_front());
          end
        end
      end
      mon_idx++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic              rw;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                nb;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_regs", regs, model_flat());
    check("reset_err", err, 1'b0);
    check("reset_cipo_oe", cipo_oe, 1'b0);
    check("reset_cipo", cipo, 1'b0);
    check("reset_wr_strobe", wr_strobe, 1'b0);
    check("reset_wr_addr", wr_addr, '0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Basic write, then read it back.
    spi_frame(1'b1, 7'h02, 8'hA5, FRAME_LEN, 1'b0);
    spi_frame(1'b0, 7'h02, 8'h00, FRAME_LEN, 1'b0);

    // Out-of-range write sets err; a valid write clears it.
    spi_frame(1'b1, 7'h05, 8'hFF, FRAME_LEN, 1'b0);
    check("err_after_bad_write", err, 1'b1);
    spi_frame(1'b1, 7'h00, 8'h3C, FRAME_LEN, 1'b0);
    check("err_after_good_write", err, 1'b0);

    // Aborted write after 4 data bits, then a full one.
    spi_frame(1'b1, 7'h01, 8'hAA, 1 + ADDR_W + 4, 1'b0);
    spi_frame(1'b1, 7'h01, 8'h55, FRAME_LEN, 1'b0);

    // Out-of-range read returns zero and flags err.
    spi_frame(1'b0, 7'h7F, 8'h00, FRAME_LEN, 1'b0);
    check("err_after_bad_read", err, 1'b1);

    // Reset in the middle of a write.
    spi_frame(1'b1, 7'h04, 8'hEE, 10, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #30;
    ncs = 1'b1;
    model_reset();
    #30;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("regs_after_midframe_rst", regs, model_flat());
    check("err_after_midframe_rst", err, 1'b0);
    check("cipo_oe_after_midframe_rst", cipo_oe, 1'b0);
    spi_frame(1'b1, 7'h04, 8'h81, FRAME_LEN, 1'b0);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, NUM_REGS));
      d  = DATA_W'($urandom);
      case ($urandom_range(0, 5))
        0:       nb = $urandom_range(1, FRAME_LEN - 1);
        1:       nb = FRAME_LEN + $urandom_range(1, 3);
        default: nb = FRAME_LEN;
      endcase
      spi_frame(rw, a, d, nb, 1'b0);
    end

    repeat (10) @(posedge clk);
    #1;
    check("final_wr_queue", wr_q.size(), 0);
    check("final_rd_queue", rd_q.size(), 0);
    check("final_regs", regs, model_flat());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
